ddr3_cmd_sequencer: RTL and testbench
=====================================

# ddr3_cmd_sequencer

Parametrised DDR3 command sequencer that sits between the CPU request interface and the DDR3 device pins, replacing the fixed RESET→INIT→IDLE controller FSM. It runs the full JEDEC power-up sequence with programmable timing: reset hold, CKE wait, MR2/MR3/MR1/MR0 loads and ZQCL. It then issues periodic auto-refresh and services single closed-page read/write requests (ACT → RD/WR → PRE). Read/write data paths are out of scope; this block produces commands and handshakes only.

## Interface
- ROW_W, 15, row address width = device ADDR width
- BA_W, 3, bank address width
- COL_W, 10, column width (≤10; A10 never used for column)
- T_RESET, 200, cycles mem_RESET_N held low after reset
- T_CKE, 500, cycles from mem_RESET_N high to CKE high
- T_XPR, 5, T_MRD, 4, T_MOD, 12, T_ZQINIT, 512: init waits, in cycles
- T_RCD, 5, T_RW, 8, T_RP, 5, T_RFC, 88, T_REFI, 6240: access and refresh waits, in cycles (all ≥1)
- MR0..MR3, 0, ROW_W-bit mode register values
- cpu_clk  in  1  single clock, all logic rising-edge
- RESET_N  in  1  synchronous, active-low reset
- req_valid  in  1  access request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ROW_W+BA_W+COL_W  {row, bank, col}
- req_ready  out  1  request accepted when req_valid && req_ready
- req_done  out  1  one-cycle pulse, access complete
- init_done  out  1  high from entry to IDLE after init until reset
- ref_overrun  out  1  sticky, a refresh interval expired with one already pending
- mem_RESET_N, CKE, CS_N, RAS_N, CAS_N, WE_N  out  1 each  device control pins
- BA  out  BA_W; ADDR  out  ROW_W  device address pins

## Operation
- Reset values: mem_RESET_N=0, CKE=0, CS_N=RAS_N=CAS_N=WE_N=1, BA=0, ADDR=0, req_ready=0, req_done=0, init_done=0, ref_overrun=0; state RST_HOLD.
- Command encodings, given as {CS_N,RAS_N,CAS_N,WE_N}:
  - NOP 0111, MRS 0000, REF 0001, PRE 0010 (A10=0, BA=bank), ACT 0011 (ADDR=row), WR 0100, RD 0101, ZQCL 0110 (A10=1).
  - RD/WR drive ADDR = zero-extended col, with A10=0.
  - BA/ADDR are 0 on NOP.
- Init states:
  - RST_HOLD (T_RESET) → CKE_WAIT (mem_RESET_N=1, T_CKE) → XPR (CKE=1, T_XPR).
  - Then MRS2 → MRS3 → MRS1 → MRS0, each spaced T_MRD; BA = MR index, ADDR = MRn.
  - MRS0 is followed by T_MOD, then ZQCL, then T_ZQINIT, then IDLE.
- Wait rule: a command state drives its command for exactly 1 cycle. NOPs follow, so the next command lands exactly T_x cycles after it.
- IDLE:
  - Pending refresh has priority. Issue REF, wait T_RFC, return to IDLE.
  - Otherwise req_ready=1 (combinationally, in IDLE with no refresh pending). On accept, latch req_addr and req_we.
  - Then ACT → T_RCD → RD/WR → T_RW → PRE → T_RP → IDLE, with req_done pulsed on the IDLE-entry cycle.
- Refresh timer:
  - Starts at init_done and counts T_REFI cycles, repeating.
  - On expiry it sets refresh_pending; issuing REF clears it.
  - If the timer expires while refresh_pending=1, ref_overrun sets and stays set until reset.
  - An in-flight access is never interrupted.
- RESET_N low at any cycle, including mid-access: next edge forces reset values and RST_HOLD. The latched request is discarded and no req_done is produced.

## Timing
- Accept at cycle 0. ACT at 1, RD/WR at 1+T_RCD, PRE at 1+T_RCD+T_RW.
- req_done and IDLE at 1+T_RCD+T_RW+T_RP. req_ready can reassert the same cycle.
- Refresh expiry and request arriving in the same cycle: REF wins, req_ready=0.
- The wait counter is 32-bit internal and loads T_x−1 on command. Timer T_REFI wraps to reload with no dead cycle.

## Structure
- ddr3_mem_pkg additions:
  - seq_state_t enum;
  - cmd_t 4-bit typedef and CMD_* constants;
  - default timing localparams.
- Sub-module ddr3_wait_timer: loadable down-counter with load/value inputs and a zero flag. It is instantiated twice, once for the state wait and once for T_REFI.

## Test plan
- Init, with T_RESET=4, T_CKE=5, T_XPR=3, T_MRD=4, T_MOD=6, T_ZQINIT=8:
  - mem_RESET_N rises at cycle 4 and CKE at 9.
  - MRS at cycles 12, 16, 20, 24 with BA=2, 3, 1, 0 and ADDR=MR2, MR3, MR1, MR0.
  - ZQCL at 30 with A10=1; init_done at 38.
- Read, with T_RCD=3, T_RW=4, T_RP=2, req_addr={row 0x1A2B, bank 5, col 0x3F}:
  - ACT at +1 with BA=5, ADDR=0x1A2B.
  - RD at +4 with ADDR=0x03F, A10=0; PRE at +8.
  - req_done at +10.
- Write: same sequence with the WR encoding. req_ready stays 0 from accept until req_done.
- Refresh, with T_REFI=50, T_RFC=10:
  - REF every 50 cycles when idle.
  - A request presented on the expiry cycle is accepted 11 cycles later.
- Overrun: with T_REFI=20 and back-to-back accesses, ref_overrun is 0 until a second expiry occurs while pending, then stays 1.
- Reset at cycle +5 of an access: all outputs return to reset values next edge, there is no req_done, and init restarts from RST_HOLD.

Source files
------------

// File: rtl/ddr3_mem_pkg.sv
// Shared types, command encodings and default timings for the DDR3 command sequencer.
// Commands are {CS_N, RAS_N, CAS_N, WE_N}.
package ddr3_mem_pkg;

    typedef enum logic [3:0] {
        S_RST_HOLD,
        S_CKE_WAIT,
        S_XPR,
        S_MRS2,
        S_MRS3,
        S_MRS1,
        S_MRS0,
        S_ZQCL,
        S_IDLE,
        S_REF,
        S_ACT,
        S_RW,
        S_PRE
    } seq_state_t;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_DES  = 4'b1111;
    localparam cmd_t CMD_NOP  = 4'b0111;
    localparam cmd_t CMD_MRS  = 4'b0000;
    localparam cmd_t CMD_REF  = 4'b0001;
    localparam cmd_t CMD_PRE  = 4'b0010;
    localparam cmd_t CMD_ACT  = 4'b0011;
    localparam cmd_t CMD_WR   = 4'b0100;
    localparam cmd_t CMD_RD   = 4'b0101;
    localparam cmd_t CMD_ZQCL = 4'b0110;

    localparam int DEF_ROW_W    = 15;
    localparam int DEF_BA_W     = 3;
    localparam int DEF_COL_W    = 10;
    localparam int DEF_T_RESET  = 200;
    localparam int DEF_T_CKE    = 500;
    localparam int DEF_T_XPR    = 5;
    localparam int DEF_T_MRD    = 4;
    localparam int DEF_T_MOD    = 12;
    localparam int DEF_T_ZQINIT = 512;
    localparam int DEF_T_RCD    = 5;
    localparam int DEF_T_RW     = 8;
    localparam int DEF_T_RP     = 5;
    localparam int DEF_T_RFC    = 88;
    localparam int DEF_T_REFI   = 6240;

endpackage

// File: rtl/ddr3_wait_timer.sv
// Loadable 32-bit down-counter that parks at zero; zero_o flags the final cycle of a wait.
module ddr3_wait_timer #(
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] value_i,
    output logic        zero_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= RESET_VAL;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != 32'd0) begin
            count_q <= count_q - 32'd1;
        end
    end

    assign zero_o = (count_q == 32'd0);

endmodule

// File: rtl/ddr3_cmd_sequencer.sv
// DDR3 power-up, periodic refresh and closed-page access sequencer.
// Each command state drives its command on its first cycle only and NOPs for the rest of its wait.
module ddr3_cmd_sequencer
    import ddr3_mem_pkg::*;
#(
    parameter int ROW_W    = DEF_ROW_W,
    parameter int BA_W     = DEF_BA_W,
    parameter int COL_W    = DEF_COL_W,
    parameter int T_RESET  = DEF_T_RESET,
    parameter int T_CKE    = DEF_T_CKE,
    parameter int T_XPR    = DEF_T_XPR,
    parameter int T_MRD    = DEF_T_MRD,
    parameter int T_MOD    = DEF_T_MOD,
    parameter int T_ZQINIT = DEF_T_ZQINIT,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RW     = DEF_T_RW,
    parameter int T_RP     = DEF_T_RP,
    parameter int T_RFC    = DEF_T_RFC,
    parameter int T_REFI   = DEF_T_REFI,
    parameter logic [ROW_W-1:0] MR0 = '0,
    parameter logic [ROW_W-1:0] MR1 = '0,
    parameter logic [ROW_W-1:0] MR2 = '0,
    parameter logic [ROW_W-1:0] MR3 = '0
) (
    input  logic                         cpu_clk,
    input  logic                         RESET_N,
    input  logic                         req_valid,
    input  logic                         req_we,
    input  logic [ROW_W+BA_W+COL_W-1:0]  req_addr,
    output logic                         req_ready,
    output logic                         req_done,
    output logic                         init_done,
    output logic                         ref_overrun,
    output logic                         mem_RESET_N,
    output logic                         CKE,
    output logic                         CS_N,
    output logic                         RAS_N,
    output logic                         CAS_N,
    output logic                         WE_N,
    output logic [BA_W-1:0]              BA,
    output logic [ROW_W-1:0]             ADDR
);

    localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1) << 10;

    seq_state_t       state_q, state_d;
    logic             first_q;
    logic [ROW_W-1:0] row_q;
    logic [BA_W-1:0]  bank_q;
    logic [COL_W-1:0] col_q;
    logic             we_q;
    logic             init_done_q, done_q, pending_q, overrun_q;

    logic        wait_zero, refi_zero, refi_expire, refresh_req;
    logic        accept, issue_ref, init_end;
    logic [31:0] wait_val;
    cmd_t        cmd;

    // The refresh timer only counts once init is complete, so its zero flag is gated here.
    assign refi_expire = init_done_q && refi_zero;
    assign refresh_req = pending_q || refi_expire;
    assign req_ready   = (state_q == S_IDLE) && !refresh_req;
    assign accept      = req_ready && req_valid;
    assign issue_ref   = (state_q == S_IDLE) && refresh_req;
    assign init_end    = (state_q == S_ZQCL) && wait_zero;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST_HOLD: if (wait_zero) state_d = S_CKE_WAIT;
            S_CKE_WAIT: if (wait_zero) state_d = S_XPR;
            S_XPR:      if (wait_zero) state_d = S_MRS2;
            S_MRS2:     if (wait_zero) state_d = S_MRS3;
            S_MRS3:     if (wait_zero) state_d = S_MRS1;
            S_MRS1:     if (wait_zero) state_d = S_MRS0;
            S_MRS0:     if (wait_zero) state_d = S_ZQCL;
            S_ZQCL:     if (wait_zero) state_d = S_IDLE;
            S_IDLE: begin
                if (refresh_req)    state_d = S_REF;
                else if (req_valid) state_d = S_ACT;
            end
            S_REF:      if (wait_zero) state_d = S_IDLE;
            S_ACT:      if (wait_zero) state_d = S_RW;
            S_RW:       if (wait_zero) state_d = S_PRE;
            S_PRE:      if (wait_zero) state_d = S_IDLE;
            default:    state_d = S_RST_HOLD;
        endcase
    end

    // The wait timer is loaded with the duration of the state being entered, minus one.
    always_comb begin
        wait_val = 32'd0;
        case (state_d)
            S_RST_HOLD: wait_val = 32'(T_RESET - 1);
            S_CKE_WAIT: wait_val = 32'(T_CKE - 1);
            S_XPR:      wait_val = 32'(T_XPR - 1);
            S_MRS2, S_MRS3, S_MRS1: wait_val = 32'(T_MRD - 1);
            S_MRS0:     wait_val = 32'(T_MOD - 1);
            S_ZQCL:     wait_val = 32'(T_ZQINIT - 1);
            S_REF:      wait_val = 32'(T_RFC - 1);
            S_ACT:      wait_val = 32'(T_RCD - 1);
            S_RW:       wait_val = 32'(T_RW - 1);
            S_PRE:      wait_val = 32'(T_RP - 1);
            default:    wait_val = 32'd0;
        endcase
    end

    ddr3_wait_timer #(
        .RESET_VAL(32'(T_RESET - 1))
    ) u_state_timer (
        .clk    (cpu_clk),
        .rst_n  (RESET_N),
        .load_i (state_d != state_q),
        .value_i(wait_val),
        .zero_o (wait_zero)
    );

    ddr3_wait_timer #(
        .RESET_VAL(32'd0)
    ) u_refi_timer (
        .clk    (cpu_clk),
        .rst_n  (RESET_N),
        .load_i (init_end || refi_expire),
        .value_i(32'(T_REFI - 1)),
        .zero_o (refi_zero)
    );

    always_ff @(posedge cpu_clk) begin
        if (!RESET_N) begin
            state_q     <= S_RST_HOLD;
            first_q     <= 1'b0;
            row_q       <= '0;
            bank_q      <= '0;
            col_q       <= '0;
            we_q        <= 1'b0;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            done_q  <= (state_q == S_PRE) && wait_zero;
            if (init_end) init_done_q <= 1'b1;
            if (accept) begin
                row_q  <= req_addr[ROW_W+BA_W+COL_W-1 -: ROW_W];
                bank_q <= req_addr[BA_W+COL_W-1 -: BA_W];
                col_q  <= req_addr[COL_W-1:0];
                we_q   <= req_we;
            end
            // A fresh expiry in the same cycle as REF issue remains pending for the next one.
            if (issue_ref) pending_q <= pending_q && refi_expire;
            else           pending_q <= pending_q || refi_expire;
            if (refi_expire && pending_q) overrun_q <= 1'b1;
        end
    end

    always_comb begin
        cmd  = (state_q == S_RST_HOLD || state_q == S_CKE_WAIT) ? CMD_DES : CMD_NOP;
        BA   = '0;
        ADDR = '0;
        if (first_q) begin
            case (state_q)
                S_MRS2: begin cmd = CMD_MRS; BA = BA_W'(2); ADDR = MR2; end
                S_MRS3: begin cmd = CMD_MRS; BA = BA_W'(3); ADDR = MR3; end
                S_MRS1: begin cmd = CMD_MRS; BA = BA_W'(1); ADDR = MR1; end
                S_MRS0: begin cmd = CMD_MRS; BA = BA_W'(0); ADDR = MR0; end
                S_ZQCL: begin cmd = CMD_ZQCL; ADDR = ADDR_A10; end
                S_REF:  cmd = CMD_REF;
                S_ACT:  begin cmd = CMD_ACT; BA = bank_q; ADDR = row_q; end
                S_RW:   begin cmd = we_q ? CMD_WR : CMD_RD; BA = bank_q; ADDR = ROW_W'(col_q); end
                S_PRE:  begin cmd = CMD_PRE; BA = bank_q; end
                default: ;
            endcase
        end
    end

    assign {CS_N, RAS_N, CAS_N, WE_N} = cmd;
    assign mem_RESET_N = (state_q != S_RST_HOLD);
    assign CKE         = (state_q != S_RST_HOLD) && (state_q != S_CKE_WAIT);
    assign req_done    = done_q;
    assign init_done   = init_done_q;
    assign ref_overrun = overrun_q;

endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
// Directed bench: init, read/write, refresh priority, mid-access reset on one instance,
// and refresh overrun on a second instance with a short refresh interval.
module tb_ddr3_cmd_sequencer;

    localparam logic [14:0] MR0V = 15'h0520;
    localparam logic [14:0] MR1V = 15'h0044;
    localparam logic [14:0] MR2V = 15'h0018;
    localparam logic [14:0] MR3V = 15'h0004;

    localparam logic [3:0] C_DES = 4'b1111, C_NOP = 4'b0111, C_MRS = 4'b0000, C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010, C_ACT = 4'b0011, C_WR = 4'b0100, C_RD = 4'b0101;
    localparam logic [3:0] C_ZQ = 4'b0110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_we;
    logic [27:0] req_addr;
    logic        m_ready, m_done, m_idone, m_ovr, m_rstn, m_cke, m_cs, m_ras, m_cas, m_we;
    logic [2:0]  m_ba;
    logic [14:0] m_addr;
    logic [3:0]  cmd;
    assign cmd = {m_cs, m_ras, m_cas, m_we};

    logic        o_rst_n, o_valid, o_req_we;
    logic [27:0] o_req_addr;
    logic        o_ready, o_done, o_idone, o_ovr, o_rstn, o_cke, o_cs, o_ras, o_cas, o_we;
    logic [2:0]  o_ba;
    logic [14:0] o_addr;

    ddr3_cmd_sequencer #(
        .T_RESET(4), .T_CKE(5), .T_XPR(3), .T_MRD(4), .T_MOD(6), .T_ZQINIT(8),
        .T_RCD(3), .T_RW(4), .T_RP(2), .T_RFC(10), .T_REFI(50),
        .MR0(MR0V), .MR1(MR1V), .MR2(MR2V), .MR3(MR3V)
    ) dut (
        .cpu_clk(clk), .RESET_N(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_ready(m_ready), .req_done(m_done), .init_done(m_idone),
        .ref_overrun(m_ovr), .mem_RESET_N(m_rstn), .CKE(m_cke), .CS_N(m_cs), .RAS_N(m_ras),
        .CAS_N(m_cas), .WE_N(m_we), .BA(m_ba), .ADDR(m_addr)
    );

    ddr3_cmd_sequencer #(
        .T_RESET(4), .T_CKE(5), .T_XPR(3), .T_MRD(4), .T_MOD(6), .T_ZQINIT(8),
        .T_RCD(3), .T_RW(30), .T_RP(2), .T_RFC(10), .T_REFI(20),
        .MR0(MR0V), .MR1(MR1V), .MR2(MR2V), .MR3(MR3V)
    ) dut_ovr (
        .cpu_clk(clk), .RESET_N(o_rst_n), .req_valid(o_valid), .req_we(o_req_we),
        .req_addr(o_req_addr), .req_ready(o_ready), .req_done(o_done), .init_done(o_idone),
        .ref_overrun(o_ovr), .mem_RESET_N(o_rstn), .CKE(o_cke), .CS_N(o_cs), .RAS_N(o_ras),
        .CAS_N(o_cas), .WE_N(o_we), .BA(o_ba), .ADDR(o_addr)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic        chk_cmd;
        logic [2:0]  ba;
        logic [14:0] addr;
        logic        rstn;
        logic        cke;
        logic        idone;
    } init_vec_t;

    typedef struct {
        int   off;
        int   kind;   // 0 NOP, 1 ACT, 2 RD/WR, 3 PRE
        logic ready;
        logic done;
    } acc_vec_t;

    init_vec_t init_tab[16];
    acc_vec_t  acc_tab[9];

    int cyc = 0;
    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " mem_RESET_N"}, 32'(m_rstn), 32'd0);
        chk({tag, " CKE"}, 32'(m_cke), 32'd0);
        chk({tag, " cmd"}, 32'(cmd), 32'(C_DES));
        chk({tag, " BA"}, 32'(m_ba), 32'd0);
        chk({tag, " ADDR"}, 32'(m_addr), 32'd0);
        chk({tag, " req_ready"}, 32'(m_ready), 32'd0);
        chk({tag, " req_done"}, 32'(m_done), 32'd0);
        chk({tag, " init_done"}, 32'(m_idone), 32'd0);
        chk({tag, " ref_overrun"}, 32'(m_ovr), 32'd0);
    endtask

    task automatic run_init(input string tag);
        init_vec_t v;
        for (int i = 0; i < 16; i++) begin
            v = init_tab[i];
            step_to(v.cyc);
            chk($sformatf("%s c%0d mem_RESET_N", tag, v.cyc), 32'(m_rstn), 32'(v.rstn));
            chk($sformatf("%s c%0d CKE", tag, v.cyc), 32'(m_cke), 32'(v.cke));
            chk($sformatf("%s c%0d init_done", tag, v.cyc), 32'(m_idone), 32'(v.idone));
            chk($sformatf("%s c%0d req_ready", tag, v.cyc), 32'(m_ready), 32'(v.idone));
            if (v.chk_cmd) begin
                chk($sformatf("%s c%0d cmd", tag, v.cyc), 32'(cmd), 32'(v.cmd));
                chk($sformatf("%s c%0d BA", tag, v.cyc), 32'(m_ba), 32'(v.ba));
                chk($sformatf("%s c%0d ADDR", tag, v.cyc), 32'(m_addr), 32'(v.addr));
            end
        end
    endtask

    // Caller is parked on the negedge of the accept cycle.
    task automatic run_access(input int base, input logic we, input logic [14:0] row,
                              input logic [2:0] bank, input logic [9:0] col);
        logic [3:0]  ecmd;
        logic [2:0]  eba;
        logic [14:0] eaddr;
        req_addr  = {row, bank, col};
        req_we    = we;
        req_valid = 1'b1;
        chk($sformatf("acc@%0d accept ready", base), 32'(m_ready), 32'd1);
        step_to(base + 1);
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step_to(base + acc_tab[i].off);
            case (acc_tab[i].kind)
                1:       begin ecmd = C_ACT; eba = bank; eaddr = row; end
                2:       begin ecmd = we ? C_WR : C_RD; eba = bank; eaddr = {5'd0, col}; end
                3:       begin ecmd = C_PRE; eba = bank; eaddr = 15'd0; end
                default: begin ecmd = C_NOP; eba = 3'd0; eaddr = 15'd0; end
            endcase
            chk($sformatf("acc@%0d +%0d cmd", base, acc_tab[i].off), 32'(cmd), 32'(ecmd));
            chk($sformatf("acc@%0d +%0d BA", base, acc_tab[i].off), 32'(m_ba), 32'(eba));
            chk($sformatf("acc@%0d +%0d ADDR", base, acc_tab[i].off), 32'(m_addr), 32'(eaddr));
            chk($sformatf("acc@%0d +%0d req_ready", base, acc_tab[i].off), 32'(m_ready), 32'(acc_tab[i].ready));
            chk($sformatf("acc@%0d +%0d req_done", base, acc_tab[i].off), 32'(m_done), 32'(acc_tab[i].done));
        end
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        o_rst_n = 1'b0; o_valid = 1'b0; o_req_we = 1'b0; o_req_addr = '0;

        init_tab[0]  = '{3,  C_DES,  1'b1, 3'd0, 15'h0,   1'b0, 1'b0, 1'b0};
        init_tab[1]  = '{4,  C_NOP,  1'b0, 3'd0, 15'h0,   1'b1, 1'b0, 1'b0};
        init_tab[2]  = '{8,  C_NOP,  1'b0, 3'd0, 15'h0,   1'b1, 1'b0, 1'b0};
        init_tab[3]  = '{9,  C_NOP,  1'b0, 3'd0, 15'h0,   1'b1, 1'b1, 1'b0};
        init_tab[4]  = '{12, C_MRS,  1'b1, 3'd2, MR2V,    1'b1, 1'b1, 1'b0};
        init_tab[5]  = '{13, C_NOP,  1'b1, 3'd0, 15'h0,   1'b1, 1'b1, 1'b0};
        init_tab[6]  = '{16, C_MRS,  1'b1, 3'd3, MR3V,    1'b1, 1'b1, 1'b0};
        init_tab[7]  = '{17, C_NOP,  1'b1, 3'd0, 15'h0,   1'b1, 1'b1, 1'b0};
        init_tab[8]  = '{20, C_MRS,  1'b1, 3'd1, MR1V,    1'b1, 1'b1, 1'b0};
        init_tab[9]  = '{24, C_MRS,  1'b1, 3'd0, MR0V,    1'b1, 1'b1, 1'b0};
        init_tab[10] = '{25, C_NOP,  1'b1, 3'd0, 15'h0,   1'b1, 1'b1, 1'b0};
        init_tab[11] = '{29, C_NOP,  1'b1, 3'd0, 15'h0,   1'b1, 1'b1, 1'b0};
        init_tab[12] = '{30, C_ZQ,   1'b1, 3'd0, 15'h400, 1'b1, 1'b1, 1'b0};
        init_tab[13] = '{31, C_NOP,  1'b1, 3'd0, 15'h0,   1'b1, 1'b1, 1'b0};
        init_tab[14] = '{37, C_NOP,  1'b1, 3'd0, 15'h0,   1'b1, 1'b1, 1'b0};
        init_tab[15] = '{38, C_NOP,  1'b1, 3'd0, 15'h0,   1'b1, 1'b1, 1'b1};

        acc_tab[0] = '{1,  1, 1'b0, 1'b0};
        acc_tab[1] = '{2,  0, 1'b0, 1'b0};
        acc_tab[2] = '{3,  0, 1'b0, 1'b0};
        acc_tab[3] = '{4,  2, 1'b0, 1'b0};
        acc_tab[4] = '{5,  0, 1'b0, 1'b0};
        acc_tab[5] = '{7,  0, 1'b0, 1'b0};
        acc_tab[6] = '{8,  3, 1'b0, 1'b0};
        acc_tab[7] = '{9,  0, 1'b0, 1'b0};
        acc_tab[8] = '{10, 0, 1'b1, 1'b1};

        // Reset, then release: the release negedge is cycle 0.
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        run_init("init");

        step_to(40);
        run_access(40, 1'b0, 15'h1A2B, 3'd5, 10'h03F);
        run_access(50, 1'b1, 15'h7FFF, 3'd2, 10'h3FF);

        // First refresh expiry lands at cycle 87; a request arriving then must wait for REF.
        step_to(86);
        chk("ref pre-expiry ready", 32'(m_ready), 32'd1);
        step_to(87);
        req_addr = {15'h0001, 3'd7, 10'h200}; req_we = 1'b0; req_valid = 1'b1;
        chk("ref wins ready", 32'(m_ready), 32'd0);
        step_to(88);
        chk("ref1 cmd", 32'(cmd), 32'(C_REF));
        chk("ref1 BA", 32'(m_ba), 32'd0);
        chk("ref1 ADDR", 32'(m_addr), 32'd0);
        chk("ref1 ready", 32'(m_ready), 32'd0);
        step_to(89);
        chk("ref1 nop", 32'(cmd), 32'(C_NOP));
        step_to(97);
        chk("ref1 end ready", 32'(m_ready), 32'd0);
        step_to(98);
        run_access(98, 1'b0, 15'h0001, 3'd7, 10'h200);
        step_to(137);
        chk("ref2 pre cmd", 32'(cmd), 32'(C_NOP));
        chk("ref2 expiry ready", 32'(m_ready), 32'd0);
        step_to(138);
        chk("ref2 cmd", 32'(cmd), 32'(C_REF));
        step_to(148);
        chk("ref2 back idle ready", 32'(m_ready), 32'd1);

        // Reset asserted on cycle +5 of an access.
        step_to(150);
        req_addr = {15'h0ABC, 3'd4, 10'h011}; req_we = 1'b1; req_valid = 1'b1;
        chk("rstacc accept ready", 32'(m_ready), 32'd1);
        step_to(151);
        req_valid = 1'b0;
        chk("rstacc ACT", 32'(cmd), 32'(C_ACT));
        step_to(155);
        rst_n = 1'b0;
        step_to(156);
        check_reset_vals("midreset");
        saw_done = 1'b0;
        while (cyc < 163) begin
            step_to(cyc + 1);
            if (m_done) saw_done = 1'b1;
        end
        chk("midreset no req_done", 32'(saw_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        run_init("reinit");

        // Overrun instance: T_REFI=20 with 35-cycle accesses back to back.
        @(negedge clk);
        o_rst_n = 1'b1;
        o_valid = 1'b1;
        o_req_addr = {15'h0123, 3'd1, 10'h004};
        cyc = 0;
        chk("ovr c0 overrun", 32'(o_ovr), 32'd0);
        step_to(38);
        chk("ovr c38 init_done", 32'(o_idone), 32'd1);
        step_to(100);
        chk("ovr c100 overrun", 32'(o_ovr), 32'd0);
        step_to(140);
        chk("ovr c140 overrun", 32'(o_ovr), 32'd1);
        step_to(250);
        chk("ovr c250 overrun sticky", 32'(o_ovr), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
